// File: rtl/branch_predictor_pkg.sv
// Shared encodings for the fetch-side branch predictor.
// Counter states, branch opcode and a saturating helper.
package branch_predictor_pkg;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    function automatic logic [31:0] sat_inc32(
        input logic [31:0] v,
        input logic        en
    );
        if (en && (v != 32'hFFFF_FFFF)) begin
            return v + 32'd1;
        end
        return v;
    endfunction

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// 2-bit saturating counter next-state function.
// Increments on taken, decrements otherwise, clamped at ST/SNT.
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    output logic [1:0] nxt
);

    // saturating step in the direction of the outcome
    always_comb begin
        nxt = ctr;
        if (taken) begin
            if (ctr != ST) nxt = ctr + 2'd1;
        end else begin
            if (ctr != SNT) nxt = ctr - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: IF lookup, EX training,
// mispredict flush/redirect and performance counters.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int IDX_BITS = 4,
    parameter int TAG_BITS = 26
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    output logic        flush,
    output logic [31:0] redirect_pc,
    output logic [31:0] br_count,
    output logic [31:0] mis_count
);

    localparam int N = 1 << IDX_BITS;

    logic                valid_q  [N];
    logic                valid_d  [N];
    logic [TAG_BITS-1:0] tag_q    [N];
    logic [TAG_BITS-1:0] tag_d    [N];
    logic [31:0]         target_q [N];
    logic [31:0]         target_d [N];
    logic [1:0]          ctr_q    [N];
    logic [1:0]          ctr_d    [N];

    logic [31:0] br_q, br_d;
    logic [31:0] mis_q, mis_d;

    logic [IDX_BITS-1:0] l_idx, u_idx;
    logic [TAG_BITS-1:0] l_tag, u_tag;
    logic                l_hit, u_hit;
    logic [1:0]          ctr_nxt;
    logic                mis;
    logic                unused_pc_lsb;

    assign unused_pc_lsb = ^{if_pc[1:0], ex_pc[1:0]};

    assign l_idx = if_pc[IDX_BITS+1:2];
    assign l_tag = if_pc[31:IDX_BITS+2];
    assign u_idx = ex_pc[IDX_BITS+1:2];
    assign u_tag = ex_pc[31:IDX_BITS+2];

    // IF lookup sees only registered contents, so no same-cycle bypass
    always_comb begin
        l_hit       = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
        pred_taken  = l_hit && ctr_q[l_idx][1];
        pred_target = pred_taken ? target_q[l_idx] : 32'h0;
    end

    // EX mispredict detection and redirect, held quiet during reset
    always_comb begin
        mis = ex_valid &&
              ((ex_taken != ex_pred_taken) ||
               (ex_taken && ex_pred_taken &&
                (ex_target != ex_pred_target)));
        flush       = rst_n && mis;
        redirect_pc = 32'h0;
        if (flush) begin
            redirect_pc = ex_taken ? ex_target : ex_pc + 32'd4;
        end
    end

    sat_counter2 u_sat (
        .ctr   (ctr_q[u_idx]),
        .taken (ex_taken),
        .nxt   (ctr_nxt)
    );

    // table training: hit trains the counter, miss allocates
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        u_hit    = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
        if (ex_valid) begin
            if (u_hit) begin
                ctr_d[u_idx] = ctr_nxt;
                if (ex_taken) target_d[u_idx] = ex_target;
            end else begin
                valid_d[u_idx]  = 1'b1;
                tag_d[u_idx]    = u_tag;
                target_d[u_idx] = ex_target;
                ctr_d[u_idx]    = ex_taken ? WT : WNT;
            end
        end
    end

    // saturating statistics
    always_comb begin
        br_d  = sat_inc32(br_q, ex_valid);
        mis_d = sat_inc32(mis_q, mis);
    end

    // state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= WNT;
            end
            br_q  <= '0;
            mis_q <= '0;
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            ctr_q    <= ctr_d;
            br_q     <= br_d;
            mis_q    <= mis_d;
        end
    end

    assign br_count  = br_q;
    assign mis_count = mis_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor.
// Expected values queued at drive time, popped at sample time.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        flush;
    logic [31:0] redirect_pc;
    logic [31:0] br_count;
    logic [31:0] mis_count;

    logic [31:0] sb [$];
    logic [31:0] e;
    int n_tot  = 0;
    int n_pass = 0;
    int m_br   = 0;
    int m_mis  = 0;

    always #5 clk = ~clk;

    branch_predictor dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .if_pc          (if_pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .ex_valid       (ex_valid),
        .ex_pc          (ex_pc),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .flush          (flush),
        .redirect_pc    (redirect_pc),
        .br_count       (br_count),
        .mis_count      (mis_count)
    );

    task automatic drive_ex(input logic [31:0] pc, input logic pt,
                            input logic [31:0] ptg, input logic tk,
                            input logic [31:0] tg);
        @(negedge clk);
        ex_valid = 1'b1; ex_pc = pc; ex_pred_taken = pt;
        ex_pred_target = ptg; ex_taken = tk; ex_target = tg;
    endtask

    task automatic idle();
        @(negedge clk);
        ex_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; if_pc = 32'h40; ex_valid = 1'b0; ex_pc = 0;
        ex_pred_taken = 0; ex_pred_target = 0; ex_taken = 0; ex_target = 0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        sb.push_back(0); sb.push_back(0); sb.push_back(0); sb.push_back(0);
        #1;
        e = sb.pop_front(); n_tot++; if (pred_taken !== e[0]) $display("FAIL reset_pred act=%0h exp=%0h", pred_taken, e[0]); else n_pass++;
        e = sb.pop_front(); n_tot++; if (pred_target !== e) $display("FAIL reset_tgt act=%0h exp=%0h", pred_target, e); else n_pass++;
        e = sb.pop_front(); n_tot++; if (br_count !== e) $display("FAIL reset_br act=%0h exp=%0h", br_count, e); else n_pass++;
        e = sb.pop_front(); n_tot++; if (mis_count !== e) $display("FAIL reset_mis act=%0h exp=%0h", mis_count, e); else n_pass++;
    endtask

    task automatic test_alloc();
        drive_ex(32'h40, 0, 0, 1, 32'h80); m_br++; m_mis++;
        sb.push_back(1); sb.push_back(32'h80);
        #1;
        e = sb.pop_front(); n_tot++; if (flush !== e[0]) $display("FAIL alloc_flush act=%0h exp=%0h", flush, e[0]); else n_pass++;
        e = sb.pop_front(); n_tot++; if (redirect_pc !== e) $display("FAIL alloc_redir act=%0h exp=%0h", redirect_pc, e); else n_pass++;
        idle(); if_pc = 32'h40;
        sb.push_back(1); sb.push_back(32'h80); sb.push_back(m_mis); sb.push_back(m_br);
        #1;
        e = sb.pop_front(); n_tot++; if (pred_taken !== e[0]) $display("FAIL alloc_pred act=%0h exp=%0h", pred_taken, e[0]); else n_pass++;
        e = sb.pop_front(); n_tot++; if (pred_target !== e) $display("FAIL alloc_tgt act=%0h exp=%0h", pred_target, e); else n_pass++;
        e = sb.pop_front(); n_tot++; if (mis_count !== e) $display("FAIL alloc_mis act=%0h exp=%0h", mis_count, e); else n_pass++;
        e = sb.pop_front(); n_tot++; if (br_count !== e) $display("FAIL alloc_br act=%0h exp=%0h", br_count, e); else n_pass++;
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 3; i++) begin
            drive_ex(32'h40, 1, 32'h80, 1, 32'h80); m_br++;
            sb.push_back(0);
            #1;
            e = sb.pop_front(); n_tot++; if (flush !== e[0]) $display("FAIL sat_flush%0d act=%0h exp=%0h", i, flush, e[0]); else n_pass++;
        end
        drive_ex(32'h40, 1, 32'h80, 0, 32'h80); m_br++; m_mis++;
        sb.push_back(1); sb.push_back(32'h44);
        #1;
        e = sb.pop_front(); n_tot++; if (flush !== e[0]) $display("FAIL sat_nt_flush act=%0h exp=%0h", flush, e[0]); else n_pass++;
        e = sb.pop_front(); n_tot++; if (redirect_pc !== e) $display("FAIL sat_nt_redir act=%0h exp=%0h", redirect_pc, e); else n_pass++;
        idle(); if_pc = 32'h40;
        sb.push_back(1); sb.push_back(32'h80); sb.push_back(m_mis);
        #1;
        e = sb.pop_front(); n_tot++; if (pred_taken !== e[0]) $display("FAIL sat_wt_pred act=%0h exp=%0h", pred_taken, e[0]); else n_pass++;
        e = sb.pop_front(); n_tot++; if (pred_target !== e) $display("FAIL sat_wt_tgt act=%0h exp=%0h", pred_target, e); else n_pass++;
        e = sb.pop_front(); n_tot++; if (mis_count !== e) $display("FAIL sat_mis act=%0h exp=%0h", mis_count, e); else n_pass++;
    endtask

    task automatic test_target();
        drive_ex(32'h40, 1, 32'h80, 1, 32'hC0); m_br++; m_mis++;
        sb.push_back(1); sb.push_back(32'hC0);
        #1;
        e = sb.pop_front(); n_tot++; if (flush !== e[0]) $display("FAIL tgt_flush act=%0h exp=%0h", flush, e[0]); else n_pass++;
        e = sb.pop_front(); n_tot++; if (redirect_pc !== e) $display("FAIL tgt_redir act=%0h exp=%0h", redirect_pc, e); else n_pass++;
        idle(); if_pc = 32'h40;
        sb.push_back(1); sb.push_back(32'hC0);
        #1;
        e = sb.pop_front(); n_tot++; if (pred_taken !== e[0]) $display("FAIL tgt_pred act=%0h exp=%0h", pred_taken, e[0]); else n_pass++;
        e = sb.pop_front(); n_tot++; if (pred_target !== e) $display("FAIL tgt_tgt act=%0h exp=%0h", pred_target, e); else n_pass++;
    endtask

    task automatic test_alias();
        drive_ex(32'h440, 0, 0, 0, 32'h500); m_br++;
        sb.push_back(0);
        #1;
        e = sb.pop_front(); n_tot++; if (flush !== e[0]) $display("FAIL alias_flush act=%0h exp=%0h", flush, e[0]); else n_pass++;
        idle(); if_pc = 32'h40;
        sb.push_back(0);
        #1;
        e = sb.pop_front(); n_tot++; if (pred_taken !== e[0]) $display("FAIL alias_old_pred act=%0h exp=%0h", pred_taken, e[0]); else n_pass++;
        if_pc = 32'h440;
        sb.push_back(0); sb.push_back(m_br);
        #1;
        e = sb.pop_front(); n_tot++; if (pred_taken !== e[0]) $display("FAIL alias_new_pred act=%0h exp=%0h", pred_taken, e[0]); else n_pass++;
        e = sb.pop_front(); n_tot++; if (br_count !== e) $display("FAIL alias_br act=%0h exp=%0h", br_count, e); else n_pass++;
    endtask

    task automatic test_same_cycle();
        drive_ex(32'h40, 0, 0, 1, 32'h80); m_br++; m_mis++;
        if_pc = 32'h40;
        sb.push_back(0); sb.push_back(1); sb.push_back(32'h80);
        #1;
        e = sb.pop_front(); n_tot++; if (pred_taken !== e[0]) $display("FAIL same_old_pred act=%0h exp=%0h", pred_taken, e[0]); else n_pass++;
        e = sb.pop_front(); n_tot++; if (flush !== e[0]) $display("FAIL same_flush act=%0h exp=%0h", flush, e[0]); else n_pass++;
        e = sb.pop_front(); n_tot++; if (redirect_pc !== e) $display("FAIL same_redir act=%0h exp=%0h", redirect_pc, e); else n_pass++;
        idle();
        sb.push_back(1); sb.push_back(32'h80); sb.push_back(0);
        #1;
        e = sb.pop_front(); n_tot++; if (pred_taken !== e[0]) $display("FAIL same_new_pred act=%0h exp=%0h", pred_taken, e[0]); else n_pass++;
        e = sb.pop_front(); n_tot++; if (pred_target !== e) $display("FAIL same_new_tgt act=%0h exp=%0h", pred_target, e); else n_pass++;
        e = sb.pop_front(); n_tot++; if (flush !== e[0]) $display("FAIL idle_flush act=%0h exp=%0h", flush, e[0]); else n_pass++;
    endtask

    task automatic test_wrap();
        drive_ex(32'hFFFF_FFFC, 1, 32'h100, 0, 32'h100); m_br++; m_mis++;
        sb.push_back(1); sb.push_back(32'h0);
        #1;
        e = sb.pop_front(); n_tot++; if (flush !== e[0]) $display("FAIL wrap_flush act=%0h exp=%0h", flush, e[0]); else n_pass++;
        e = sb.pop_front(); n_tot++; if (redirect_pc !== e) $display("FAIL wrap_redir act=%0h exp=%0h", redirect_pc, e); else n_pass++;
        idle();
        sb.push_back(m_br); sb.push_back(m_mis);
        #1;
        e = sb.pop_front(); n_tot++; if (br_count !== e) $display("FAIL wrap_br act=%0h exp=%0h", br_count, e); else n_pass++;
        e = sb.pop_front(); n_tot++; if (mis_count !== e) $display("FAIL wrap_mis act=%0h exp=%0h", mis_count, e); else n_pass++;
    endtask

    task automatic test_reset_mid();
        drive_ex(32'h40, 0, 0, 1, 32'h200);
        if_pc = 32'h40;
        #2 rst_n = 1'b0;
        sb.push_back(0); sb.push_back(0); sb.push_back(0);
        sb.push_back(0); sb.push_back(0);
        #1;
        e = sb.pop_front(); n_tot++; if (pred_taken !== e[0]) $display("FAIL rmid_pred act=%0h exp=%0h", pred_taken, e[0]); else n_pass++;
        e = sb.pop_front(); n_tot++; if (flush !== e[0]) $display("FAIL rmid_flush act=%0h exp=%0h", flush, e[0]); else n_pass++;
        e = sb.pop_front(); n_tot++; if (redirect_pc !== e) $display("FAIL rmid_redir act=%0h exp=%0h", redirect_pc, e); else n_pass++;
        e = sb.pop_front(); n_tot++; if (br_count !== e) $display("FAIL rmid_br act=%0h exp=%0h", br_count, e); else n_pass++;
        e = sb.pop_front(); n_tot++; if (mis_count !== e) $display("FAIL rmid_mis act=%0h exp=%0h", mis_count, e); else n_pass++;
        @(posedge clk);
        @(negedge clk); ex_valid = 1'b0; rst_n = 1'b1;
        sb.push_back(0); sb.push_back(0);
        #1;
        e = sb.pop_front(); n_tot++; if (pred_taken !== e[0]) $display("FAIL rmid_drop_pred act=%0h exp=%0h", pred_taken, e[0]); else n_pass++;
        e = sb.pop_front(); n_tot++; if (br_count !== e) $display("FAIL rmid_drop_br act=%0h exp=%0h", br_count, e); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_alloc();
        test_saturate();
        test_target();
        test_alias();
        test_same_cycle();
        test_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout act=running exp=finished");
        $fatal(1);
    end

endmodule
